// File: rtl/fetch_queue_mw.sv
// Multi-wide FWFT fetch queue between imem responses and decode; squashes in-flight responses after a flush.
// Latency: enqueue-to-dequeue 1 cycle; enq_ready is a pure function of current occupancy (no same-cycle slot reuse).
module fetch_queue_mw #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int ENQ_W   = 2,
    parameter int DEQ_W   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_imem_req_fire,
    input  logic                          i_imem_resp,
    input  logic [ENQ_W-1:0]              i_enq_valid,
    input  logic [ENQ_W*DATA_W-1:0]       i_enq_data,
    input  logic [ENQ_W*32-1:0]           i_enq_pc,
    output logic                          o_enq_ready,
    output logic [DEQ_W-1:0]              o_deq_valid,
    output logic [DEQ_W*DATA_W-1:0]       o_deq_data,
    output logic [DEQ_W*32-1:0]           o_deq_pc,
    input  logic [$clog2(DEQ_W+1)-1:0]    i_deq_take,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_empty,
    output logic                          o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [31:0]       r_mem_pc   [DEPTH];
    logic [AW:0]       r_head;
    logic [AW:0]       r_tail;
    logic [CW-1:0]     r_count;
    logic [OW-1:0]     r_out;
    logic [OW-1:0]     r_squash;

    logic              w_enq_fire;
    logic [CW-1:0]     w_enq_cnt;
    logic [CW-1:0]     w_enq_n;
    logic [CW-1:0]     w_take;
    logic [CW-1:0]     w_deq_n;
    logic [OW-1:0]     w_out_next;
    logic [OW-1:0]     w_out_less_resp;
    logic [OW-1:0]     w_squash_next;
    logic [AW-1:0]     w_idx;

    always_comb begin
        o_enq_ready = (r_count <= CW'(DEPTH - ENQ_W));
        w_enq_cnt   = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            w_enq_cnt = w_enq_cnt + CW'(i_enq_valid[i]);
        end
        w_enq_fire = i_imem_resp && o_enq_ready && (r_squash == '0) && !i_flush;
        w_enq_n    = w_enq_fire ? w_enq_cnt : '0;
        w_take     = CW'(i_deq_take);
        w_deq_n    = i_flush ? '0 : ((w_take > r_count) ? r_count : w_take);
    end

    // Responses still in flight at a flush are owed a squash; a response landing in the flush cycle is already accounted.
    always_comb begin
        w_out_less_resp = (i_imem_resp && r_out != '0) ? r_out - OW'(1) : r_out;
        w_out_next      = r_out;
        if (i_imem_req_fire && !i_imem_resp && r_out != OW'(MAX_OUT)) begin
            w_out_next = r_out + OW'(1);
        end else if (!i_imem_req_fire && i_imem_resp && r_out != '0) begin
            w_out_next = r_out - OW'(1);
        end
        w_squash_next = r_squash;
        if (i_flush) begin
            w_squash_next = w_out_less_resp;
        end else if (i_imem_resp && r_squash != '0) begin
            w_squash_next = r_squash - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_squash <= '0;
        end else begin
            r_out    <= w_out_next;
            r_squash <= w_squash_next;
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + w_deq_n;
                r_tail  <= r_tail + w_enq_n;
                r_count <= r_count + w_enq_n - w_deq_n;
            end
        end
    end

    // Storage is never cleared; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_W; i++) begin
            if (w_enq_fire && i_enq_valid[i]) begin
                r_mem_data[r_tail[AW-1:0] + AW'(i)] <= i_enq_data[i*DATA_W +: DATA_W];
                r_mem_pc[r_tail[AW-1:0] + AW'(i)]   <= i_enq_pc[i*32 +: 32];
            end
        end
    end

    always_comb begin
        o_deq_valid = '0;
        o_deq_data  = '0;
        o_deq_pc    = '0;
        w_idx       = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            w_idx = r_head[AW-1:0] + AW'(i);
            if (r_count > CW'(i)) begin
                o_deq_valid[i]                 = 1'b1;
                o_deq_data[i*DATA_W +: DATA_W] = r_mem_data[w_idx];
                o_deq_pc[i*32 +: 32]           = r_mem_pc[w_idx];
            end
        end
        o_count = r_count;
        o_empty = (r_count == '0);
        o_full  = (r_count == CW'(DEPTH));
    end
endmodule

// File: tb/tb_fetch_queue_mw.sv
// Randomized and directed bench for fetch_queue_mw: queue-level reference model feeding a scoreboard monitor.
module tb_fetch_queue_mw;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 16;
    localparam int ENQ_W   = 2;
    localparam int DEQ_W   = 2;
    localparam int MAX_OUT = 4;
    localparam int TW      = $clog2(DEQ_W + 1);
    localparam int CW      = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0]       pc;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    req_fire;
    logic                    imem_resp;
    logic [ENQ_W-1:0]        enq_valid;
    logic [ENQ_W*DATA_W-1:0] enq_data;
    logic [ENQ_W*32-1:0]     enq_pc;
    logic                    enq_ready;
    logic [DEQ_W-1:0]        deq_valid;
    logic [DEQ_W*DATA_W-1:0] deq_data;
    logic [DEQ_W*32-1:0]     deq_pc;
    logic [TW-1:0]           deq_take;
    logic [CW-1:0]           count;
    logic                    empty;
    logic                    full;

    fetch_queue_mw #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_imem_req_fire(req_fire), .i_imem_resp(imem_resp),
        .i_enq_valid(enq_valid), .i_enq_data(enq_data), .i_enq_pc(enq_pc), .o_enq_ready(enq_ready),
        .o_deq_valid(deq_valid), .o_deq_data(deq_data), .o_deq_pc(deq_pc), .i_deq_take(deq_take),
        .o_count(count), .o_empty(empty), .o_full(full)
    );

    always #5 clk = ~clk;

    // Reference model: the queue contents, outstanding requests and responses still owed a squash.
    ent_t        mq[$];
    ent_t        exp_q[$];
    int          st_q[$];
    int          m_out = 0;
    int          m_sq  = 0;
    logic [31:0] next_pc = 32'h100;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit fl, input bit fire, input bit resp, input int nv, input int take);
        ent_t e;
        int   n;
        bit   rdy;
        @(negedge clk); #1;
        st_q.push_back(mq.size());
        flush     = fl;
        req_fire  = fire;
        imem_resp = resp;
        deq_take  = TW'(take);
        for (int i = 0; i < ENQ_W; i++) begin
            enq_valid[i]                 = (i < nv);
            enq_pc[i*32 +: 32]           = next_pc + 32'(4 * i);
            enq_data[i*DATA_W +: DATA_W] = $urandom;
        end
        if (resp && nv > 0) next_pc += 32'(4 * nv);
        rdy = (DEPTH - mq.size()) >= ENQ_W;
        if (fl) begin
            mq.delete();
            m_sq = (m_out - int'(resp) > 0) ? m_out - int'(resp) : 0;
        end else begin
            n = (take < mq.size()) ? take : mq.size();
            repeat (n) exp_q.push_back(mq.pop_front());
            if (resp) begin
                if (m_sq > 0) m_sq--;
                else if (rdy) begin
                    for (int i = 0; i < nv; i++) begin
                        e.pc   = enq_pc[i*32 +: 32];
                        e.data = enq_data[i*DATA_W +: DATA_W];
                        mq.push_back(e);
                    end
                end
            end
        end
        m_out = m_out + int'(fire) - int'(resp);
        if (m_out > MAX_OUT) m_out = MAX_OUT;
        if (m_out < 0) m_out = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        repeat (DEPTH / DEQ_W + 1) cycle(0, 0, 0, 0, DEQ_W);
    endtask

    task automatic pk_count(input string nm, input int v);
        @(posedge clk); #1;
        chk(nm, 64'(count), 64'(v));
    endtask

    // Monitor: compares status and every consumed lane against what the model expects.
    initial begin
        int   c;
        int   n;
        ent_t e;
        forever begin
            @(negedge clk); #3;
            if (st_q.size() != 0) begin
                c = st_q.pop_front();
                chk("count", 64'(count), 64'(c));
                chk("empty", 64'(empty), 64'(c == 0));
                chk("full", 64'(full), 64'(c == DEPTH));
                chk("enq_ready", 64'(enq_ready), 64'((DEPTH - c) >= ENQ_W));
                for (int i = 0; i < DEQ_W; i++) begin
                    chk("deq_valid", 64'(deq_valid[i]), 64'(c > i));
                    if (c <= i) begin
                        chk("idle_lane_pc", 64'(deq_pc[i*32 +: 32]), 64'(0));
                        chk("idle_lane_data", 64'(deq_data[i*DATA_W +: DATA_W]), 64'(0));
                    end
                end
                n = flush ? 0 : ((int'(deq_take) < c) ? int'(deq_take) : c);
                for (int i = 0; i < n; i++) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underrun", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("deq_pc", 64'(deq_pc[i*32 +: 32]), 64'(e.pc));
                        chk("deq_data", 64'(deq_data[i*DATA_W +: DATA_W]), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 0; req_fire = 0; imem_resp = 0;
        enq_valid = '0; enq_data = '0; enq_pc = '0; deq_take = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_enq_ready", 64'(enq_ready), 64'(1));
        chk("rst_deq_valid", 64'(deq_valid), 64'(0));
        chk("rst_deq_pc", 64'(deq_pc), 64'(0));
        chk("rst_deq_data", 64'(deq_data), 64'(0));
        @(negedge clk); rst = 1'b0;

        // First group: PCs 0x100/0x104 visible one cycle later.
        cycle(0, 0, 1, 2, 0);
        pk_count("first_count", 2);
        chk("first_valid", 64'(deq_valid), 64'(2'b11));
        chk("first_pc", 64'(deq_pc), 64'h0000_0104_0000_0100);
        drain();

        // Fill to the brim; the extra group must be dropped.
        repeat (7) cycle(0, 0, 1, 2, 0);
        pk_count("fill7_count", 14);
        chk("fill7_ready", 64'(enq_ready), 64'(1));
        cycle(0, 0, 1, 2, 0);
        pk_count("fill8_count", 16);
        chk("fill8_full", 64'(full), 64'(1));
        chk("fill8_ready", 64'(enq_ready), 64'(0));
        cycle(0, 0, 1, 2, 0);
        pk_count("overfill_count", 16);
        drain();

        // Steady enq 2 / deq 2 across pointer wrap.
        cycle(0, 0, 1, 2, 0);
        repeat (20) cycle(0, 0, 1, 2, 2);
        pk_count("steady_count", 2);
        drain();

        // Three requests in flight at flush are squashed; the fourth response lands.
        repeat (3) cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 2, 0);
        pk_count("squash3_count", 0);
        cycle(0, 0, 1, 2, 0);
        pk_count("post_squash_count", 2);
        drain();

        // Flush coinciding with a response and a new request, two outstanding: one squash.
        repeat (2) cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 1, 2, 0);
        cycle(0, 0, 1, 2, 0);
        pk_count("squash1_count", 0);
        cycle(0, 0, 1, 2, 0);
        pk_count("squash1_after", 2);

        // Over-take with one entry left.
        cycle(0, 0, 0, 0, 1);
        pk_count("one_left", 1);
        cycle(0, 0, 0, 0, 2);
        pk_count("overtake_count", 0);
        chk("overtake_empty", 64'(empty), 64'(1));

        // Reset beats flush: nothing is squashed afterwards.
        repeat (2) cycle(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        rst = 1'b1; flush = 1'b1; req_fire = 0; imem_resp = 0; deq_take = '0;
        mq.delete(); m_out = 0; m_sq = 0;
        @(negedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        cycle(0, 0, 1, 2, 0);
        pk_count("rst_wins_count", 2);
        drain();

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2), (k < 200) ? $urandom_range(0, 1) : $urandom_range(0, 2));
        end
        drain();
        idle(2);
        @(negedge clk); #5;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue_mw.md
# fetch_queue_mw

Multi-wide instruction fetch queue sitting between the instruction-memory response path and decode/dispatch. It accepts up to ENQ_W instructions (data + PC) per cycle and presents up to DEQ_W head entries first-word-fall-through. It tracks outstanding imem requests so that responses already in flight when a flush occurs are squashed rather than enqueued, without blocking on full.

## Interface
Parameters:
- DATA_W, 32, instruction bits per entry
- DEPTH, 16, entries; power of 2, ≥ max(ENQ_W, DEQ_W)
- ENQ_W, 2, enqueue lanes per cycle
- DEQ_W, 2, dequeue lanes per cycle
- MAX_OUT, 4, maximum outstanding imem requests tracked

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  redirect; discard all contents and squash in-flight responses
- imem_req_fire  in  1  an imem request was accepted this cycle
- imem_resp  in  1  imem response valid; qualifies enq_valid
- enq_valid  in  ENQ_W  per-lane valid, contiguous from lane 0
- enq_data  in  ENQ_W×DATA_W  instruction per lane
- enq_pc  in  ENQ_W×32  PC per lane
- enq_ready  out  1  free entries ≥ ENQ_W
- deq_valid  out  DEQ_W  lane i valid iff count > i
- deq_data  out  DEQ_W×DATA_W  entry at head+i
- deq_pc  out  DEQ_W×32  PC at head+i
- deq_take  in  $clog2(DEQ_W+1)  entries consumed this cycle
- count  out  $clog2(DEPTH)+1  occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- State: head/tail pointers with extra wrap bit, count, outstanding counter (0..MAX_OUT), squash counter (0..MAX_OUT).
- Enqueue: enq_n = popcount(enq_valid) when imem_resp && enq_ready && squash==0 && !flush, else 0. Lane i written to tail+i (mod DEPTH); tail += enq_n.
- Enqueue while !enq_ready: whole group dropped, no state change except outstanding/squash accounting.
- Dequeue: deq_n = min(deq_take, count); head += deq_n. deq_take > count is clamped, never underflows. Ignored during flush.
- Simultaneous enq/deq: count_next = count + enq_n − deq_n; enq_ready from current count only (no same-cycle bypass of freed slots).
- Outstanding: out_next = out + imem_req_fire − imem_resp; saturating at MAX_OUT and 0.
- Flush cycle: head, tail, count ← 0; enqueue and dequeue that cycle discarded; squash ← out − imem_resp (requests fired in the flush cycle belong to the new path and are not squashed).
- Squash: while squash > 0, each imem_resp is dropped and squash decrements. A flush during squash reloads squash per the rule above.
- deq outputs combinational from storage/head; invalid lanes drive 0 (not X).
- Entry storage is not cleared on flush/rst; validity comes only from count.

## Timing
- Reset: head=tail=count=out=squash=0; empty=1, full=0, enq_ready=1, deq_valid=0, deq_data/pc=0.
- Enqueue-to-dequeue latency: 1 cycle (written at edge N, deq_valid[0] high after edge N).
- Flush takes effect at the next edge; contents empty the cycle after flush asserts.
- flush and rst same cycle: rst wins (squash=0).
- Wrap-around: lane writes/reads crossing index DEPTH−1 wrap to 0 within the same cycle.

## Test plan
- Reset, then enq 2 lanes (pc 0x100, 0x104) -> next cycle count=2, deq_valid=2'b11, deq_pc={0x104,0x100}.
- DEPTH=16, ENQ_W=2: fill 8 groups with no dequeue -> full=1, enq_ready=0 at count=15..16 boundary (enq_ready=0 at count≥15); a 9th group is dropped, count stays 16.
- Steady state enq 2 / deq_take=2 for 20 cycles -> count constant, pointers wrap, PCs emerge in order with no loss.
- Fire 3 requests, flush, then 3 responses with valid data -> all dropped, count=0, squash 3→0; 4th response enqueued.
- Flush in the same cycle as a response and a new request fire with 2 outstanding -> squash=1; next response dropped, following one enqueued.
- deq_take=2 with count=1 -> count=0, no underflow, empty=1.
